// File: rtl/sobel_window_ctrl.sv
// Raster-scan frame sequencer for a combinational Sobel core.
// Two line buffers plus per-row column shift registers build the 3x3
// neighbourhood. Only interior pixels produce results, and each result is
// registered into a valid/ready output stream.

package sobel_control;
    localparam int PIXEL_WIDTH = 8;

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] pix2;
        logic [PIXEL_WIDTH-1:0] pix1;
        logic [PIXEL_WIDTH-1:0] pix0;
    } sobel_vector;

    typedef struct packed {
        sobel_vector vector2;
        sobel_vector vector1;
        sobel_vector vector0;
    } sobel_matrix;
endpackage

module sobel_window_ctrl
    import sobel_control::*;
#(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic [PIXEL_WIDTH-1:0] in_pixel_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output sobel_matrix            window_o,
    input  logic [PIXEL_WIDTH-1:0] edge_i,
    output logic [PIXEL_WIDTH-1:0] out_pixel_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_last_o
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FILL   = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] FLUSH  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;

    logic accept;
    logic col_last;
    logic row_last;
    logic capture;

    // Line buffers: lb_top holds row r-2, lb_mid holds row r-1.
    logic [PIXEL_WIDTH-1:0] lb_top [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb_mid [IMG_WIDTH];

    // Per-row column history; index 0 = oldest row (r-2), 2 = current row.
    logic [PIXEL_WIDTH-1:0] cur_col [3];
    logic [PIXEL_WIDTH-1:0] d1_reg  [3];
    logic [PIXEL_WIDTH-1:0] d2_reg  [3];

    assign col_last = (col_reg == CW'(IMG_WIDTH - 1));
    assign row_last = (row_reg == RW'(IMG_HEIGHT - 1));
    assign accept   = in_valid_i & in_ready_o;
    assign capture  = accept && (state_reg == STREAM) && (col_reg >= CW'(2));

    assign busy_o = (state_reg != IDLE);
    assign done_o = (state_reg == DONE);

    assign cur_col[0] = lb_top[col_reg];
    assign cur_col[1] = lb_mid[col_reg];
    assign cur_col[2] = in_pixel_i;

    // Input readiness depends only on state and the output register, never on accept.
    always_comb begin
        in_ready_o = 1'b0;
        case (state_reg)
            FILL:    in_ready_o = 1'b1;
            STREAM:  in_ready_o = !out_valid_o || out_ready_i;
            default: in_ready_o = 1'b0;
        endcase
    end

    // Frame sequencing: fill two rows, stream the rest, drain the output, pulse done.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = FILL;
            FILL:    if (accept && row_reg == RW'(1) && col_last) state_next = STREAM;
            STREAM:  if (accept && row_last && col_last) state_next = FLUSH;
            FLUSH:   if (!out_valid_o || out_ready_i) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Raster position: column wraps per line, row saturates at the last line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (state_reg == IDLE && start_i) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_reg <= '0;
                if (!row_last) row_reg <= row_reg + RW'(1);
            end else begin
                col_reg <= col_reg + CW'(1);
            end
        end
    end

    // Line buffers shift one row down at the current column on every accepted pixel.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb_top[col_reg] <= lb_mid[col_reg];
            lb_mid[col_reg] <= in_pixel_i;
        end
    end

    // Column history per row: d2 is column c-2, d1 is column c-1.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_col_shift
            always_ff @(posedge clk_i) begin
                if (accept) begin
                    d2_reg[gi] <= d1_reg[gi];
                    d1_reg[gi] <= cur_col[gi];
                end
            end
        end
    endgenerate

    assign window_o.vector0.pix0 = d2_reg[0];
    assign window_o.vector0.pix1 = d1_reg[0];
    assign window_o.vector0.pix2 = cur_col[0];
    assign window_o.vector1.pix0 = d2_reg[1];
    assign window_o.vector1.pix1 = d1_reg[1];
    assign window_o.vector1.pix2 = cur_col[1];
    assign window_o.vector2.pix0 = d2_reg[2];
    assign window_o.vector2.pix1 = d1_reg[2];
    assign window_o.vector2.pix2 = cur_col[2];

    // Output register: a fresh capture beats a completing handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_pixel_o <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else if (capture) begin
            out_pixel_o <= edge_i;
            out_valid_o <= 1'b1;
            out_last_o  <= row_last && col_last;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on an 8x6 frame with a behavioural
// Sobel core driving edge_i from window_o.
module tb_sobel_window_ctrl;
    import sobel_control::*;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NRES = (W - 2) * (H - 2);

    localparam int K_FLAT = 0;
    localparam int K_STEP = 1;
    localparam int K_SAT  = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic                   busy;
    logic                   done;
    logic [PIXEL_WIDTH-1:0] in_pixel = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    sobel_matrix            window;
    logic [PIXEL_WIDTH-1:0] edge_v;
    logic [PIXEL_WIDTH-1:0] out_pixel;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   out_last;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .in_pixel_i (in_pixel),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .window_o   (window),
        .edge_i     (edge_v),
        .out_pixel_o(out_pixel),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_last_o (out_last)
    );

    // Behavioural Sobel core: |Gx|+|Gy|, saturated to the pixel range.
    function automatic logic [PIXEL_WIDTH-1:0] sobel_model(sobel_matrix m);
        int gx, gy, mag, maxv;
        gx = (int'(m.vector0.pix2) + 2 * int'(m.vector1.pix2) + int'(m.vector2.pix2))
           - (int'(m.vector0.pix0) + 2 * int'(m.vector1.pix0) + int'(m.vector2.pix0));
        gy = (int'(m.vector2.pix0) + 2 * int'(m.vector2.pix1) + int'(m.vector2.pix2))
           - (int'(m.vector0.pix0) + 2 * int'(m.vector0.pix1) + int'(m.vector0.pix2));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag  = gx + gy;
        maxv = (1 << PIXEL_WIDTH) - 1;
        if (mag > maxv) mag = maxv;
        return PIXEL_WIDTH'(mag);
    endfunction

    assign edge_v = sobel_model(window);

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [PIXEL_WIDTH-1:0] pix_of(input int kind, input int c);
        if (kind == K_FLAT) return PIXEL_WIDTH'(50);
        if (kind == K_STEP) return (c < 4) ? PIXEL_WIDTH'(0) : PIXEL_WIDTH'(10);
        return (c < 4) ? PIXEL_WIDTH'(0) : {PIXEL_WIDTH{1'b1}};
    endfunction

    // Hand-computed result per output column (cols 2..7) for each frame kind.
    function automatic int exp_of(input int kind, input int c);
        int step_row[6] = '{0, 0, 40, 40, 0, 0};
        int sat_row[6]  = '{0, 0, 255, 255, 0, 0};
        if (kind == K_FLAT) return 0;
        if (kind == K_STEP) return step_row[c - 2];
        return sat_row[c - 2];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_pixel"}, out_pixel, 0);
        check({tag, "_out_last"},  out_last, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_in_ready"},  in_ready, 0);
    endtask

    // One frame; bp enables random output stalls, start_at pulses start_i
    // mid-frame, abort_at asserts reset just before that pixel is offered.
    task automatic run_frame(input string name, input int kind, input bit bp,
                             input int start_at, input int abort_at);
        int idx = 0, k = 0, cyc = 0, dones = 0, stall_cnt = 0;
        int last_acc_cyc = -1, done_cyc = -1, held_pix = 0, held_last = 0;
        int r, c;
        bit acc, stalled = 0, finished = 0;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after_start"}, busy, 1);

        while (!finished && cyc < 2000) begin
            if (bp) begin
                if (stall_cnt > 0) begin
                    out_ready = 1'b0;
                    stall_cnt--;
                end else begin
                    out_ready = 1'b1;
                    if ($urandom_range(0, 3) == 0) stall_cnt = $urandom_range(1, 5);
                end
            end else begin
                out_ready = 1'b1;
            end
            in_valid = 1'b1;
            in_pixel = (idx < W * H) ? pix_of(kind, idx % W) : '0;
            start    = (start_at >= 0 && idx == start_at);

            if (abort_at >= 0 && idx == abort_at) begin
                check({name, "_pre_abort_valid"}, out_valid, 1);
                check({name, "_pre_abort_pix"}, out_pixel, 40);
                rst = 1'b1;
                #1;
                check_all_zero({name, "_async_rst"});
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
                start    = 1'b0;
                $display("[TB] %s: reset at pixel %0d after %0d results", name, idx, k);
                return;
            end

            #1;
            acc = in_valid && in_ready;
            if (stalled) begin
                check({name, "_stall_valid"}, out_valid, 1);
                check({name, "_stall_pix"}, out_pixel, held_pix);
                check({name, "_stall_last"}, out_last, held_last);
            end
            stalled = out_valid && !out_ready;
            if (stalled) begin
                held_pix  = out_pixel;
                held_last = out_last;
                check({name, "_stall_no_accept"}, in_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (k < NRES) begin
                    check({name, "_result_pix"}, out_pixel, exp_of(kind, k % (W - 2) + 2));
                    check({name, "_result_last"}, out_last, (k == NRES - 1) ? 1 : 0);
                end
                k++;
            end

            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (acc) begin
                r = idx / W;
                c = idx % W;
                if (r >= 2 && c >= 2) begin
                    check({name, "_latency_valid"}, out_valid, 1);
                    check({name, "_latency_pix"}, out_pixel, exp_of(kind, c));
                end
                last_acc_cyc = cyc - 1;
                idx++;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 2) finished = 1;
            @(negedge clk);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({name, "_completed"}, finished, 1);
        check({name, "_accepted"}, idx, W * H);
        check({name, "_result_count"}, k, NRES);
        check({name, "_done_pulses"}, dones, 1);
        if (!bp) check({name, "_done_latency"}, done_cyc - last_acc_cyc, 2);
        check({name, "_idle_after"}, busy, 0);
        $display("[TB] %s: %0d pixels accepted, %0d results, %0d done pulses", name, idx, k, dones);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_in_ready", in_ready, 0);
            check("idle_busy", busy, 0);
            check("idle_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        $display("[TB] reset/idle: no accept without start");

        run_frame("flat",      K_FLAT, 1'b0, -1, -1);
        run_frame("step",      K_STEP, 1'b0, -1, -1);
        run_frame("step_bp",   K_STEP, 1'b1, -1, -1);
        run_frame("sat",       K_SAT,  1'b0, -1, -1);
        run_frame("start_mid", K_STEP, 1'b0, 20, -1);
        run_frame("abort",     K_STEP, 1'b0, -1, 30);
        run_frame("post_abort", K_FLAT, 1'b0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running expected finished");
        $fatal(1, "timeout");
    end

endmodule
